hazard_sequencer: RTL and testbench

// Central hazard/stall sequencer for the 5-stage RV32I pipeline. Drives stall/flush enables of the
// F/D, D/E, E/M and M/W pipeline registers and the E-stage forwarding muxes. Tracks variable-latency

---
 rtl/pipe_pkg.sv | 19 +
 rtl/fwd_unit.sv | 24 ++
 rtl/hazard_sequencer.sv | 171 +++++++++++++++++
 tb/tb_hazard_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding selects,
// result-source encodings and hazard FSM states.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } hz_state_t;

endpackage

// File: rtl/fwd_unit.sv
// E-stage forwarding select for one source operand.
// The M-stage result is newer than W, so it wins.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    output fwd_sel_t   fwd_o
);

    // Pick the youngest in-flight writer of this operand; x0 is never forwarded.
    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
            fwd_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes, forwarding,
// variable-latency data-memory wait with timeout, and perf counters.
module hazard_sequencer
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int WCW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    hz_state_t        state_q;
    logic [WCW-1:0]   wait_cnt_q;
    logic             mem_err_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic     lw_stall;
    logic     miss;
    logic     mem_stall;
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    fwd_unit u_fwd_a (
        .rs_e_i        (Rs1E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs_e_i        (Rs2E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_b)
    );

    // Hazard detection: load-use in D/E and an outstanding memory miss in M.
    always_comb begin
        lw_stall  = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0)
                    && ((RdE == Rs1D) || (RdE == Rs2D));
        miss      = MemReqM && !MemReadyM;
        mem_stall = miss || (state_q == ERR);
    end

    // Stall/flush fan-out; a memory stall freezes everything and bubbles W.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!rst) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushE = lw_stall || PCSrcE;
                FlushD = PCSrcE;
            end
        end
    end

    // Memory wait FSM: count consecutive miss cycles, trap to ERR on timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (miss) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= WCW'(1);
                    end
                end
                WAIT: begin
                    if (!miss) begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q   <= ERR;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCW'(1);
                    end
                end
                ERR: begin
                    mem_err_q <= 1'b1;
                end
                default: begin
                    state_q    <= RUN;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

    // Saturating next-state for the stall-cycle and flush-event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!mem_stall && PCSrcE && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign MemErr      = mem_err_q;
    assign StallCycles = stall_cnt_q;
    assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: behavioural model with
// per-cycle comparison plus directed literal checks.
module tb_hazard_sequencer;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] Rs1D = 0, Rs2D = 0, Rs1E = 0, Rs2E = 0;
    logic [4:0] RdE = 0, RdM = 0, RdW = 0;
    logic [1:0] ResultSrcE = 0;
    logic RegWriteM = 0, RegWriteW = 0, PCSrcE = 0;
    logic MemReqM = 0, MemReadyM = 0;
    logic StallF, StallD, StallE, StallM;
    logic FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic MemErr;
    logic [CW-1:0] StallCycles, FlushCount;

    int checks = 0;
    int errors = 0;

    // model state
    int m_run;
    bit m_err;
    int m_stalls;
    int m_flushes;

    hazard_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 1;
        return 0;
    endfunction

    function automatic bit lw_hit();
        return ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    function automatic bit mem_hold();
        return (MemReqM && !MemReadyM) || m_err;
    endfunction

    // Model: count consecutive missed cycles of the current access.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run     <= 0;
            m_err     <= 1'b0;
            m_stalls  <= 0;
            m_flushes <= 0;
        end else begin
            if (!m_err) begin
                if (MemReqM && !MemReadyM) begin
                    m_run <= m_run + 1;
                    if (m_run + 1 >= TO) m_err <= 1'b1;
                end else begin
                    m_run <= 0;
                end
            end
            if ((mem_hold() || lw_hit()) && m_stalls < CMAX)
                m_stalls <= m_stalls + 1;
            if (!mem_hold() && PCSrcE && m_flushes < CMAX)
                m_flushes <= m_flushes + 1;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!rst) begin
            bit h, l;
            h = mem_hold();
            l = lw_hit();
            assert (!(l && PCSrcE)) else $error("load-use and branch both set");
            chk("cyc_StallF", StallF, h | l);
            chk("cyc_StallD", StallD, h | l);
            chk("cyc_StallE", StallE, h);
            chk("cyc_StallM", StallM, h);
            chk("cyc_FlushW", FlushW, h);
            chk("cyc_FlushD", FlushD, !h && PCSrcE);
            chk("cyc_FlushE", FlushE, !h && (PCSrcE || l));
            chk("cyc_FwdA", ForwardAE, fwd(Rs1E));
            chk("cyc_FwdB", ForwardBE, fwd(Rs2E));
            chk("cyc_MemErr", MemErr, m_err);
            chk("cyc_StallCycles", StallCycles, m_stalls);
            chk("cyc_FlushCount", FlushCount, m_flushes);
        end
    end

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0; ResultSrcE = 0;
        RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #3;
        chk("rst_StallF", StallF, 0);
        chk("rst_FlushW", FlushW, 0);
        chk("rst_MemErr", MemErr, 0);
        chk("rst_StallCycles", StallCycles, 0);
        do_reset();

        // load-use
        ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
        #1;
        chk("lu_StallF", StallF, 1);
        chk("lu_StallD", StallD, 1);
        chk("lu_FlushE", FlushE, 1);
        chk("lu_FlushD", FlushD, 0);
        tick();
        idle();
        #1;
        chk("lu_StallCycles", StallCycles, 1);
        chk("lu_release", StallF, 0);
        ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
        #1;
        chk("lu_x0_StallF", StallF, 0);
        tick();
        idle();
        #1;
        chk("lu_x0_StallCycles", StallCycles, 1);

        // forwarding
        RdM = 3; RdW = 3; RegWriteM = 1; RegWriteW = 1; Rs1E = 3; Rs2E = 3;
        #1;
        chk("fwd_M", ForwardAE, 2);
        chk("fwd_M_B", ForwardBE, 2);
        RegWriteM = 0;
        #1;
        chk("fwd_W", ForwardAE, 1);
        RdM = 0; RdW = 0; RegWriteM = 1; Rs1E = 0; Rs2E = 0;
        #1;
        chk("fwd_x0", ForwardAE, 0);
        tick();
        idle();

        // branch
        do_reset();
        PCSrcE = 1;
        #1;
        chk("br_FlushD", FlushD, 1);
        chk("br_FlushE", FlushE, 1);
        chk("br_StallF", StallF, 0);
        tick();
        idle();
        #1;
        chk("br_FlushCount", FlushCount, 1);

        // memory wait with branch frozen in E
        do_reset();
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_StallM", StallM, 1);
            chk("mw_FlushW", FlushW, 1);
            chk("mw_FlushD", FlushD, 0);
            tick();
        end
        MemReadyM = 1;
        #1;
        chk("mw_rel_StallF", StallF, 0);
        chk("mw_rel_FlushW", FlushW, 0);
        chk("mw_rel_FlushD", FlushD, 1);
        tick();
        idle();
        #1;
        chk("mw_StallCycles", StallCycles, 3);
        chk("mw_FlushCount", FlushCount, 1);
        chk("mw_MemErr", MemErr, 0);

        // mixed vectors
        do_reset();
        for (int i = 0; i < 60; i++) begin
            Rs1D = 5'($urandom_range(0, 3));
            Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3));
            Rs2E = 5'($urandom_range(0, 3));
            RdE = 5'($urandom_range(0, 3));
            RdM = 5'($urandom_range(0, 3));
            RdW = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemReqM = ($urandom_range(0, 3) == 0);
            MemReadyM = 1'($urandom_range(0, 1));
            PCSrcE = lw_hit() ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
        end
        idle();

        // timeout
        do_reset();
        MemReqM = 1; MemReadyM = 0;
        repeat (4) tick();
        idle();
        #1;
        chk("to_MemErr", MemErr, 1);
        chk("to_StallF", StallF, 1);
        chk("to_StallM", StallM, 1);
        chk("to_FlushW", FlushW, 1);
        repeat (20) tick();
        chk("to_sat_StallCycles", StallCycles, CMAX);

        // ready on the would-be timeout cycle
        do_reset();
        MemReqM = 1; MemReadyM = 0;
        repeat (3) tick();
        MemReadyM = 1;
        #1;
        chk("late_StallF", StallF, 0);
        tick();
        idle();
        #1;
        chk("late_MemErr", MemErr, 0);
        tick();
        chk("late_idle_StallF", StallF, 0);

        // async reset mid-wait, between clock edges
        do_reset();
        MemReqM = 1; MemReadyM = 0;
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_StallF", StallF, 0);
        chk("ar_FlushW", FlushW, 0);
        chk("ar_StallCycles", StallCycles, 0);
        chk("ar_MemErr", MemErr, 0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ar_after_StallF", StallF, 0);
        tick();
        chk("ar_after_StallCycles", StallCycles, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
